operand_exec: RTL and testbench

Executes one arithmetic/logic operation on the operand registers produced by the accumulator stage (r0, r1, r2). The block sits directly downstream of the accumulator and is launched by the same op event that clears the accumulator's valid bits. It latches the operands and opcode at launch. Single-cycle ops complete in one execute cycle; multiply ops use an iterative shift-add datapath. The result, flags and the launching control counter are presented with a one-cycle done pulse.

---
 rtl/operand_exec.sv | 188 ++++++++++++++++++
 tb/tb_operand_exec.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_exec.sv
// Operand execute unit: latches accumulator operands and runs one ALU op,
// or an iterative shift-add multiply / multiply-accumulate.
module operand_exec #(
  parameter int W     = 8,
  parameter int CTR_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_start,
  input  logic [2:0]       opcode,
  input  logic [W-1:0]     r0,
  input  logic [W-1:0]     r1,
  input  logic [W-1:0]     r2,
  input  logic [CTR_W-1:0] control_ctr,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     result,
  output logic             carry,
  output logic             zero,
  output logic [CTR_W-1:0] op_ctr
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MULT,
    S_ACC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]       r_op;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_c;
  logic [CTR_W-1:0] r_ctr;
  logic [2*W-1:0]   r_mcand;
  logic [W-1:0]     r_mplier;
  logic [2*W-1:0]   r_prod;
  logic [CW-1:0]    r_iter;
  logic [W-1:0]     r_result;
  logic             r_carry;
  logic             r_zero;
  logic [CTR_W-1:0] r_op_ctr;

  logic [W:0]       w_add;
  logic [W:0]       w_sub;
  logic [W:0]       w_shl;
  logic [W:0]       w_shr;
  logic [W-1:0]     w_alu_res;
  logic             w_alu_c;
  logic [2*W-1:0]   w_prod_nx;
  logic [2*W:0]     w_mac;
  logic             w_last;
  logic             w_launch;

  assign w_launch = (r_state == S_IDLE) && op_start;
  assign w_last   = (r_iter == CW'(W - 1));

  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};
  // Extra bit on each side catches the last bit shifted out.
  assign w_shl = {1'b0, r_a} << r_b[2:0];
  assign w_shr = {r_a, 1'b0} >> r_b[2:0];

  assign w_prod_nx = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_mac     = {1'b0, r_prod} + {{(W+1){1'b0}}, r_c};

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    unique case (r_op)
      3'b000: begin
        w_alu_res = w_add[W-1:0];
        w_alu_c   = w_add[W];
      end
      3'b001: begin
        w_alu_res = w_sub[W-1:0];
        w_alu_c   = w_sub[W];
      end
      3'b010: w_alu_res = r_a & r_b;
      3'b011: w_alu_res = r_a ^ r_b;
      3'b100: begin
        w_alu_res = w_shl[W-1:0];
        w_alu_c   = w_shl[W];
      end
      3'b101: begin
        w_alu_res = w_shr[W:1];
        w_alu_c   = w_shr[0];
      end
      default: begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (op_start) begin
          w_next = (opcode[2:1] == 2'b11) ? S_MULT : S_EXEC;
        end
      end
      S_EXEC: w_next = S_DONE;
      S_MULT: begin
        if (w_last) begin
          w_next = r_op[0] ? S_ACC : S_DONE;
        end
      end
      S_ACC:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_ctr    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_iter   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b1;
      r_op_ctr <= '0;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_op     <= opcode;
        r_a      <= r0;
        r_b      <= r1;
        r_c      <= r2;
        r_ctr    <= control_ctr;
        r_mcand  <= {{W{1'b0}}, r0};
        r_mplier <= r1;
        r_prod   <= '0;
        r_iter   <= '0;
      end
      if (r_state == S_EXEC) begin
        r_result <= w_alu_res;
        r_carry  <= w_alu_c;
        r_zero   <= (w_alu_res == '0);
        r_op_ctr <= r_ctr;
      end
      if (r_state == S_MULT) begin
        r_prod   <= w_prod_nx;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        // Counter parks at W-1 rather than wrapping.
        if (!w_last) begin
          r_iter <= r_iter + 1'b1;
        end
        if (w_last && !r_op[0]) begin
          r_result <= w_prod_nx[W-1:0];
          r_carry  <= |w_prod_nx[2*W-1:W];
          r_zero   <= (w_prod_nx[W-1:0] == '0);
          r_op_ctr <= r_ctr;
        end
      end
      if (r_state == S_ACC) begin
        r_result <= w_mac[W-1:0];
        r_carry  <= |w_mac[2*W:W];
        r_zero   <= (w_mac[W-1:0] == '0);
        r_op_ctr <= r_ctr;
      end
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign carry  = r_carry;
  assign zero   = r_zero;
  assign op_ctr = r_op_ctr;

endmodule

// File: tb/tb_operand_exec.sv
// Bench for operand_exec: random and directed ops, scoreboard of
// expected completions checked by an independent monitor.
module tb_operand_exec;

  logic        clk;
  logic        reset;
  logic        op_start;
  logic [2:0]  opcode;
  logic [7:0]  r0;
  logic [7:0]  r1;
  logic [7:0]  r2;
  logic [11:0] control_ctr;
  logic        busy;
  logic        done;
  logic [7:0]  result;
  logic        carry;
  logic        zero;
  logic [11:0] op_ctr;

  operand_exec #(.W(8), .CTR_W(12)) dut (
    .clk(clk),
    .reset(reset),
    .op_start(op_start),
    .opcode(opcode),
    .r0(r0),
    .r1(r1),
    .r2(r2),
    .control_ctr(control_ctr),
    .busy(busy),
    .done(done),
    .result(result),
    .carry(carry),
    .zero(zero),
    .op_ctr(op_ctr)
  );

  typedef struct {
    int res;
    int cy;
    int z;
    int ctr;
    int due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic rst_q = 1'b0;
  logic [7:0]  p_res;
  logic        p_cy;
  logic        p_z;
  logic [11:0] p_ctr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int op, input int a, input int b,
                                 input int c, input int ctr, input int lc);
    exp_t e;
    int   s;
    int   sh;
    sh = b % 8;
    e.cy = 0;
    e.due = lc + 1;
    case (op)
      0: begin s = a + b; e.res = s % 256; e.cy = (s >= 256) ? 1 : 0; end
      1: begin e.res = (a - b + 256) % 256; e.cy = (a < b) ? 1 : 0; end
      2: e.res = a & b;
      3: e.res = a ^ b;
      4: begin
        e.res = (a << sh) % 256;
        e.cy  = (sh == 0) ? 0 : ((a >> (8 - sh)) & 1);
      end
      5: begin
        e.res = a >> sh;
        e.cy  = (sh == 0) ? 0 : ((a >> (sh - 1)) & 1);
      end
      6: begin
        s = a * b; e.res = s % 256; e.cy = (s >= 256) ? 1 : 0;
        e.due = lc + 8;
      end
      default: begin
        s = a * b + c; e.res = s % 256; e.cy = (s >= 256) ? 1 : 0;
        e.due = lc + 9;
      end
    endcase
    e.z = (e.res == 0) ? 1 : 0;
    e.ctr = ctr;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_q) begin
      p_res = result; p_cy = carry; p_z = zero; p_ctr = op_ctr;
    end else if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", int'(result), e.res);
        chk("carry", int'(carry), e.cy);
        chk("zero", int'(zero), e.z);
        chk("op_ctr", int'(op_ctr), e.ctr);
        chk("latency", cyc, e.due);
      end
      p_res = result; p_cy = carry; p_z = zero; p_ctr = op_ctr;
    end else begin
      chk("hold", int'({p_res, p_cy, p_z, p_ctr}),
          int'({result, carry, zero, op_ctr}));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_op(input int op, input int a, input int b, input int c,
                        input int ctr, input int spam);
    int n;
    wait_idle();
    opcode = 3'(op);
    r0 = 8'(a);
    r1 = 8'(b);
    r2 = 8'(c);
    control_ctr = 12'(ctr);
    op_start = 1'b1;
    q.push_back(model(op, a, b, c, ctr, cyc + 1));
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_launch", int'(busy), 1);
    n = 0;
    while (busy && n < 40) begin
      if (spam == 2) op_start = 1'b1;
      else if (spam == 1) op_start = 1'($urandom_range(0, 1));
      else op_start = 1'b0;
      if (spam != 0) begin
        opcode = 3'($urandom);
        r0 = 8'($urandom);
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        control_ctr = 12'($urandom);
      end
      @(negedge clk);
      n++;
    end
    if (busy) chk("op_timeout", 1, 0);
    op_start = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_carry"}, int'(carry), 0);
    chk({tag, "_zero"}, int'(zero), 1);
    chk({tag, "_op_ctr"}, int'(op_ctr), 0);
  endtask

  function automatic int pick8();
    int k;
    k = $urandom_range(0, 5);
    if (k == 0) return 0;
    if (k == 1) return 255;
    return $urandom_range(0, 255);
  endfunction

  initial begin
    int n;
    reset = 1'b1;
    op_start = 1'b1;
    opcode = 3'b110;
    r0 = 8'd3;
    r1 = 8'd3;
    r2 = 8'd0;
    control_ctr = 12'd9;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    reset = 1'b0;
    op_start = 1'b0;
    @(negedge clk);

    run_op(0, 200, 100, 0, 5, 0);
    run_op(1, 5, 7, 0, 6, 0);
    run_op(3, 8'h5A, 8'h5A, 0, 7, 0);
    run_op(6, 13, 11, 0, 8, 0);
    run_op(6, 16, 16, 0, 9, 0);
    run_op(7, 10, 10, 50, 10, 0);
    run_op(7, 16, 16, 1, 11, 0);
    run_op(4, 8'h81, 1, 0, 12, 0);
    run_op(5, 8'h81, 0, 0, 13, 0);
    run_op(6, 255, 255, 0, 14, 2);
    run_op(7, 255, 255, 255, 15, 2);
    run_op(0, 1, 2, 0, 16, 2);

    wait_idle();
    opcode = 3'b110;
    r0 = 8'd200;
    r1 = 8'd200;
    control_ctr = 12'd77;
    op_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    op_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outs("abort");
    reset = 1'b0;
    op_start = 1'b0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      run_op($urandom_range(0, 7), pick8(), pick8(), pick8(),
             $urandom_range(0, 4095), $urandom_range(0, 2));
    end

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
